// File: rtl/button_input_ctrl_pkg.sv
// Shared types and constants for the button front end (package btn_pkg).
package btn_pkg;

    // Per-channel press/repeat state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

    // Channel assignment of the player buttons
    localparam int BTN_RIGHT  = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_ROTATE = 2;
    localparam int BTN_DOWN   = 3;

    // Auto-repeat on right, left and down; rotate fires once per press
    localparam logic [3:0] DEFAULT_REPEAT_MASK = 4'b1011;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_input_ctrl_if.sv
// Button bundle between the board pins / game logic and button_input_ctrl.
interface button_input_ctrl_if #(
    parameter int NUM_BUTTONS = 4
);
    logic [NUM_BUTTONS-1:0] btn_raw;
    logic                   enable;
    logic [NUM_BUTTONS-1:0] btn_pulse;
    logic [NUM_BUTTONS-1:0] btn_level;
    logic                   any_pulse;

    modport master (
        output btn_raw, enable,
        input  btn_pulse, btn_level, any_pulse
    );

    modport slave (
        input  btn_raw, enable,
        output btn_pulse, btn_level, any_pulse
    );
endinterface

// File: rtl/button_input_ctrl_channel.sv
// One button channel: 2-flop synchroniser, debounce, press/repeat FSM.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 1000000,
    parameter int REPEAT_DELAY_CYCLES = 20000000,
    parameter int REPEAT_RATE_CYCLES  = 5000000,
    parameter bit REPEAT_EN           = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    input  logic i_enable,
    output logic o_pulse,
    output logic o_level
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_W = $clog2(max_i(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_level;
    logic [RPT_W-1:0] r_rpt_cnt;
    logic             r_pulse;
    btn_state_e       r_state;

    logic w_s;
    logic w_accept;
    logic w_press;
    logic w_release;

    assign w_s       = r_sync[1];
    assign w_accept  = (w_s != r_level) && (r_db_cnt == DB_LAST);
    assign w_press   = w_accept & w_s;
    assign w_release = w_accept & ~w_s;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else if (w_s == r_level) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_db_cnt <= '0;
            r_level  <= w_s;
        end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

    // Press/repeat FSM with registered pulse; release always beats a due repeat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_rpt_cnt <= '0;
            r_pulse   <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_rpt_cnt <= '0;
                    if (w_press) begin
                        r_state <= HELD;
                        r_pulse <= i_enable;
                    end
                end
                HELD: begin
                    if (w_release) begin
                        r_state   <= IDLE;
                        r_rpt_cnt <= '0;
                    end else if (!i_enable) begin
                        r_rpt_cnt <= '0;
                    end else if (REPEAT_EN && (r_rpt_cnt == DELAY_LAST)) begin
                        r_state   <= REPEAT;
                        r_rpt_cnt <= '0;
                        r_pulse   <= 1'b1;
                    end else if (r_rpt_cnt != '1) begin
                        r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
                    end
                end
                REPEAT: begin
                    // Dropping back to HELD while disabled makes the first pulse after
                    // re-enable wait the full initial delay rather than the rate.
                    if (w_release) begin
                        r_state   <= IDLE;
                        r_rpt_cnt <= '0;
                    end else if (!i_enable) begin
                        r_state   <= HELD;
                        r_rpt_cnt <= '0;
                    end else if (r_rpt_cnt == RATE_LAST) begin
                        r_rpt_cnt <= '0;
                        r_pulse   <= 1'b1;
                    end else if (r_rpt_cnt != '1) begin
                        r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_rpt_cnt <= '0;
                end
            endcase
        end
    end

    assign o_pulse = r_pulse;
    assign o_level = r_level;

endmodule

// File: rtl/button_input_ctrl.sv
// Button front end: per-channel sync/debounce/repeat plus pulse merging.
// Optional macro BUTTON_ONEHOT_ARB_EN: serialise pulses one channel per cycle
// (lowest index first) through a pending register, adding one cycle of latency.
module button_input_ctrl
    import btn_pkg::*;
#(
    parameter int                     NUM_BUTTONS         = 4,
    parameter int                     DEBOUNCE_CYCLES     = 1000000,
    parameter int                     REPEAT_DELAY_CYCLES = 20000000,
    parameter int                     REPEAT_RATE_CYCLES  = 5000000,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK         = NUM_BUTTONS'(DEFAULT_REPEAT_MASK)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    button_input_ctrl_if.slave    bus
);

    if ((NUM_BUTTONS < 1) || (DEBOUNCE_CYCLES < 1) ||
        (REPEAT_DELAY_CYCLES < 1) || (REPEAT_RATE_CYCLES < 1)) begin : g_bad_params
        $error("button_input_ctrl: NUM_BUTTONS and all cycle counts must be >= 1");
    end

    logic [NUM_BUTTONS-1:0] w_ch_pulse;
    logic [NUM_BUTTONS-1:0] w_ch_level;
    logic [NUM_BUTTONS-1:0] w_pulse_out;

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
            .REPEAT_EN           (REPEAT_MASK[gi])
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_raw    (bus.btn_raw[gi]),
            .i_enable (bus.enable),
            .o_pulse  (w_ch_pulse[gi]),
            .o_level  (w_ch_level[gi])
        );
    end

`ifdef BUTTON_ONEHOT_ARB_EN
    logic [NUM_BUTTONS-1:0] r_pending;
    logic [NUM_BUTTONS-1:0] r_pulse;
    logic [NUM_BUTTONS-1:0] w_req;
    logic [NUM_BUTTONS-1:0] w_grant;

    // Merge new pulses into pending and isolate the lowest requesting channel
    always_comb begin
        w_req   = r_pending | w_ch_pulse;
        w_grant = w_req & (~w_req + NUM_BUTTONS'(1));
    end

    // Issue one pulse per cycle; disabling the game discards anything queued
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_pulse   <= '0;
        end else if (!bus.enable) begin
            r_pending <= '0;
            r_pulse   <= '0;
        end else begin
            r_pending <= w_req & ~w_grant;
            r_pulse   <= w_grant;
        end
    end

    assign w_pulse_out = r_pulse;
`else
    assign w_pulse_out = w_ch_pulse;
`endif

    assign bus.btn_pulse = w_pulse_out;
    assign bus.btn_level = w_ch_level;
    assign bus.any_pulse = |w_pulse_out;

endmodule

// File: tb/tb_button_input_ctrl.sv
// Scoreboard bench for button_input_ctrl: directed scenarios plus random stimulus
// against a behavioural model. Honours BUTTON_ONEHOT_ARB_EN when defined.
module tb_button_input_ctrl;

    localparam int NB = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;
    localparam logic [NB-1:0] MASK = 4'b1011;
`ifdef BUTTON_ONEHOT_ARB_EN
    localparam int ARB_LAT = 1;
`else
    localparam int ARB_LAT = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    button_input_ctrl_if #(.NUM_BUTTONS(NB)) bif ();

    button_input_ctrl #(
        .NUM_BUTTONS         (NB),
        .DEBOUNCE_CYCLES     (DB),
        .REPEAT_DELAY_CYCLES (RD),
        .REPEAT_RATE_CYCLES  (RR),
        .REPEAT_MASK         (MASK)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    typedef struct {
        logic [NB-1:0] pulse;
        logic [NB-1:0] level;
    } exp_t;

    exp_t sb_q[$];
    int   plog[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   edge_no = 0;
    int   t0      = 0;

    // Behavioural model state
    logic [NB-1:0] m_s1, m_s, m_level, m_held, m_pend, m_gen_prev;
    int            m_mis[NB];
    int            m_elapsed[NB];
    int            m_target[NB];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_no, act, exp);
    endtask

    task automatic model_clear();
        m_s1 = '0; m_s = '0; m_level = '0; m_held = '0; m_pend = '0; m_gen_prev = '0;
        for (int i = 0; i < NB; i++) begin
            m_mis[i] = 0; m_elapsed[i] = 0; m_target[i] = RD;
        end
    endtask

    // One clock edge of the reference behaviour; pushes the expected outputs
    task automatic model_edge(input logic [NB-1:0] raw, input logic en, input logic rst);
        logic [NB-1:0] gen, outp, req;
        logic          press, rel;
        exp_t          e;
        gen = '0; outp = '0; req = '0;
        if (!rst) begin
            model_clear();
        end else begin
            for (int i = 0; i < NB; i++) begin
                press = 1'b0; rel = 1'b0;
                if (m_s[i] != m_level[i]) begin
                    m_mis[i]++;
                    if (m_mis[i] == DB) begin
                        m_level[i] = m_s[i];
                        m_mis[i] = 0;
                        press = m_level[i];
                        rel = ~m_level[i];
                    end
                end else begin
                    m_mis[i] = 0;
                end
                m_s[i]  = m_s1[i];
                m_s1[i] = raw[i];
                if (press) begin
                    m_held[i] = 1'b1; m_elapsed[i] = 0; m_target[i] = RD; gen[i] = en;
                end else if (rel) begin
                    m_held[i] = 1'b0;
                end else if (m_held[i]) begin
                    if (!en) begin
                        m_elapsed[i] = 0; m_target[i] = RD;
                    end else begin
                        m_elapsed[i]++;
                        if (MASK[i] && m_elapsed[i] == m_target[i]) begin
                            gen[i] = 1'b1; m_elapsed[i] = 0; m_target[i] = RR;
                        end
                    end
                end
            end
`ifdef BUTTON_ONEHOT_ARB_EN
            if (!en) begin
                m_pend = '0;
            end else begin
                req = m_pend | m_gen_prev;
                for (int i = 0; i < NB; i++)
                    if (req[i] && outp == '0) outp[i] = 1'b1;
                m_pend = req & ~outp;
            end
            m_gen_prev = gen;
`else
            outp = gen;
`endif
        end
        e.pulse = outp;
        e.level = m_level;
        sb_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation, log pulses
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("btn_pulse", 32'(bif.btn_pulse), 32'(e.pulse));
            check("btn_level", 32'(bif.btn_level), 32'(e.level));
            check("any_pulse", 32'(bif.any_pulse), 32'(|e.pulse));
        end
        for (int i = 0; i < NB; i++)
            if (bif.btn_pulse[i] === 1'b1) plog.push_back(i * 1000 + (edge_no - t0));
    end

    task automatic step(input logic [NB-1:0] raw, input logic en, input logic rst);
        bif.btn_raw = raw;
        bif.enable  = en;
        reset_n     = rst;
        @(posedge clk);
        edge_no++;
        model_edge(raw, en, rst);
        #1;
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        #1;
        check("async_reset_pulse", 32'(bif.btn_pulse), 32'd0);
        check("async_reset_level", 32'(bif.btn_level), 32'd0);
        check("async_reset_any",   32'(bif.any_pulse), 32'd0);
        sb_q.delete();
        model_clear();
    endtask

    task automatic begin_scn();
        plog.delete();
        t0 = edge_no;
    endtask

    task automatic end_scn(input string name, input int exp_q[$]);
        check({name, "_count"}, 32'(plog.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < plog.size(); k++)
            check({name, "_edge"}, 32'(plog[k]), 32'(exp_q[k]));
    endtask

    initial begin
        int            ex[$];
        logic [NB-1:0] raw;
        logic          en;

        bif.btn_raw = '0;
        bif.enable  = 1'b1;
        model_clear();
        for (int j = 0; j < 3; j++) step('0, 1'b1, 1'b0);
        for (int j = 0; j < 5; j++) step('0, 1'b1, 1'b1);

        // Clean press on channel 0
        begin_scn();
        for (int j = 0; j < 8; j++)  step(4'b0001, 1'b1, 1'b1);
        for (int j = 0; j < 20; j++) step(4'b0000, 1'b1, 1'b1);
        ex.delete(); ex.push_back(6 + ARB_LAT);
        end_scn("clean_press", ex);

        // Bounce on channel 3; release lands on the cycle the first repeat is due
        begin_scn();
        for (int j = 0; j < 20; j++) begin
            raw = '0;
            raw[3] = (j < 10) ? ((j % 4) >= 2) : 1'b1;
            step(raw, 1'b1, 1'b1);
        end
        for (int j = 0; j < 20; j++) step(4'b0000, 1'b1, 1'b1);
        ex.delete(); ex.push_back(3000 + 16 + ARB_LAT);
        end_scn("bounce", ex);

        // Auto-repeat on channel 1
        begin_scn();
        for (int j = 0; j < 40; j++) step(4'b0010, 1'b1, 1'b1);
        for (int j = 0; j < 20; j++) step(4'b0000, 1'b1, 1'b1);
        ex.delete(); ex.push_back(1000 + 6 + ARB_LAT);
        for (int t = 16; t <= 43; t += 3) ex.push_back(1000 + t + ARB_LAT);
        end_scn("auto_repeat", ex);

        // Channel 2 has repeat masked off
        begin_scn();
        for (int j = 0; j < 40; j++) step(4'b0100, 1'b1, 1'b1);
        for (int j = 0; j < 20; j++) step(4'b0000, 1'b1, 1'b1);
        ex.delete(); ex.push_back(2000 + 6 + ARB_LAT);
        end_scn("no_repeat", ex);

        // Enable gating: press while disabled, enable at edge 20
        begin_scn();
        for (int j = 0; j < 40; j++) step(4'b0001, (j >= 20), 1'b1);
        for (int j = 0; j < 20; j++) step(4'b0000, 1'b1, 1'b1);
        ex.delete();
        for (int t = 30; t <= 45; t += 3) ex.push_back(t + ARB_LAT);
        end_scn("enable_gate", ex);

        // Reset during hold, released with the button still held
        begin_scn();
        for (int j = 0; j < 12; j++) step(4'b0001, 1'b1, 1'b1);
        assert_reset();
        for (int j = 12; j < 14; j++) step(4'b0001, 1'b1, 1'b0);
        for (int j = 14; j < 30; j++) step(4'b0001, 1'b1, 1'b1);
        for (int j = 0; j < 20; j++)  step(4'b0000, 1'b1, 1'b1);
        ex.delete();
        ex.push_back(6 + ARB_LAT); ex.push_back(20 + ARB_LAT);
        ex.push_back(30 + ARB_LAT); ex.push_back(33 + ARB_LAT);
        end_scn("reset_hold", ex);

`ifdef BUTTON_ONEHOT_ARB_EN
        // Simultaneous presses are serialised lowest index first
        begin_scn();
        for (int j = 0; j < 8; j++)  step(4'b0101, 1'b1, 1'b1);
        for (int j = 0; j < 20; j++) step(4'b0000, 1'b1, 1'b1);
        ex.delete(); ex.push_back(7); ex.push_back(2008);
        end_scn("arbitration", ex);
`endif

        // Random stimulus checked cycle by cycle against the model
        raw = '0;
        en  = 1'b1;
        for (int c = 0; c < 700; c++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 99) < (((c / 100) % 2) ? 4 : 15)) raw[i] = ~raw[i];
            if ($urandom_range(0, 99) < 2) en = ~en;
            if (c == 350) begin
                assert_reset();
                step(raw, en, 1'b0);
            end
            step(raw, en, 1'b1);
        end

        #20;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
